ps2_key_ctrl: RTL
=================

# ps2_key_ctrl

Scancode sequencer between the PS/2 receiver FIFO and the display/application logic. It pops bytes from the receiver FIFO with the `ready`/`nextdata_n` handshake and decodes PS/2 set-2 prefixes (E0 extended, F0 break, E1 pause). It tracks the currently held key and suppresses typematic repeats. It then publishes one-cycle make/break events, a held-key register and a press counter.

## Interface
- `PAUSE_LEN`, default 7: number of bytes following E1 that are swallowed as the pause sequence.
- `clk`  in  1  system clock. All logic updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data`  in  8  byte at the head of the receiver FIFO. Valid while `ready`=1.
- `ready`  in  1  receiver FIFO non-empty.
- `nextdata_n`  out  1  active-low pop strobe to the receiver FIFO.
- `event_stb`  out  1  one-cycle pulse marking a decoded make or break event.
- `event_break`  out  1  1 = break, 0 = make. Held until the next event.
- `event_code`  out  8  code of the last event, without prefix. Held until the next event.
- `event_ext`  out  1  last event carried E0. Held until the next event.
- `key_valid`  out  1  a key is currently held.
- `key_code`  out  8  code of the held key. Retains its last value when `key_valid`=0.
- `key_ext`  out  1  held key is extended.
- `press_cnt`  out  8  count of distinct key presses. Wraps 255 to 0.
- `err`  out  1  sticky: keyboard reported error byte 00 or FF.

## Operation
- States: IDLE, DECODE, SKIP.
- Internal registers:
  - `byte_r` (8): captured byte.
  - `ext_pend`, `brk_pend`: prefix flags.
  - `skip_cnt` (3): bytes remaining in a pause sequence.
  - `in_pause`: set while a pause sequence is being swallowed.
- IDLE:
  - If `ready`=1: drive `nextdata_n`=0 (combinational, same cycle), capture `byte_r`<=`data`, go to DECODE.
  - Otherwise `nextdata_n`=1 and stay in IDLE.
- DECODE processes `byte_r` with `nextdata_n`=1, then returns to IDLE. Exception: a byte that starts a pause sequence goes to SKIP.
  - E0: `ext_pend`<=1. No event.
  - F0: `brk_pend`<=1. No event.
  - E1: `skip_cnt`<=`PAUSE_LEN`, clear both prefixes, go to SKIP.
  - AA, FA, EE, FE: ignored. Clear prefixes.
  - 00, FF: `err`<=1. Clear prefixes.
  - Any other code c with `brk_pend`=1 (break):
    - `event_stb`=1, `event_break`<=1, `event_code`<=c, `event_ext`<=`ext_pend`.
    - If `key_valid` and {`key_ext`,`key_code`}=={`ext_pend`,c}: `key_valid`<=0.
    - Break of a non-held key leaves the held-key register unchanged.
  - Any other code c with `brk_pend`=0 and a match with the held key (typematic repeat): no event, no count.
  - Any other code c with `brk_pend`=0 and no match (new make):
    - `event_stb`=1, `event_break`<=0, `event_code`<=c, `event_ext`<=`ext_pend`.
    - `key_valid`<=1, `key_code`<=c, `key_ext`<=`ext_pend`.
    - `press_cnt`<=`press_cnt`+1.
  - Prefixes are cleared after every non-prefix byte.
- SKIP: pops and discards bytes through the normal handshake.
  - SKIP behaves like IDLE for popping, but every byte decrements `skip_cnt`.
  - When `skip_cnt` reaches 0, the FSM emits a make event: `event_code`=E1, `event_ext`=0, `event_stb`=1, `press_cnt`+1. `key_*` is unchanged.
  - The FSM then returns to IDLE.
- Only one key is tracked. A new make while another key is held replaces the held key.

## Timing
- Reset values: `nextdata_n`=1, `event_stb`=0, `event_break`=0, `event_code`=00, `event_ext`=0, `key_valid`=0, `key_code`=00, `key_ext`=0, `press_cnt`=00, `err`=0. State is IDLE and all internal registers are 0.
- `nextdata_n` is low for exactly one cycle per byte, only in a cycle where `ready`=1 and `rst`=0. The byte is captured in the same cycle it is popped.
- Throughput: one byte per 2 cycles. Back-to-back FIFO bytes produce `nextdata_n` low on alternate cycles.
- Event latency: `event_stb` is high in the cycle after the pop of the final byte, i.e. the DECODE cycle. Registered outputs update at the end of that cycle.
- `rst` asserted at any point wins: no pop in that cycle, and pending prefixes, SKIP and `skip_cnt` are abandoned. Bytes left in the FIFO are decoded fresh after reset.
- `ready` dropping mid-sequence (between E0, F0 and the code byte) retains the prefixes indefinitely.
- `press_cnt` wraps FF to 00 with no flag.

## Test plan
- Reset, then FIFO 1C, F0, 1C → one make event (1C, ext 0), `key_valid`=1 and `press_cnt`=1; then one break event, `key_valid`=0. Each pop is exactly one cycle low.
- 1C, 1C, 1C, F0, 1C → a single make event and `press_cnt`=1 (repeats suppressed), then a break event.
- E0, 75, E0, F0, 75 → make with `event_ext`=1, `key_code`=75, `key_ext`=1; break with `event_ext`=1. Plain 75 while E0-75 is held → new make, `press_cnt`+1.
- E1, 14, 77, E1, F0, 14, F0, 77 → exactly one make event (E1) after the 8th pop. `key_valid` is unchanged and there is no break event.
- Preload `press_cnt` via 256 distinct make/break pairs → wraps to 00. Byte FF → `err`=1 and stays set until `rst`.
- Assert `rst` between E0 and 75 → no event for the 75 prefix state. The 75 after reset decodes as a plain make with ext 0, and `nextdata_n`=1 during the reset cycle.

Source files
------------

// File: rtl/ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_ctrl
// Purpose  : PS/2 set-2 scancode sequencer. Pops the receiver FIFO, decodes
//            E0/F0/E1 prefixes, tracks one held key and emits make/break events.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_ctrl #(
    parameter int PAUSE_LEN = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       ready,
    output logic       nextdata_n,
    output logic       event_stb,
    output logic       event_break,
    output logic [7:0] event_code,
    output logic       event_ext,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic [7:0] press_cnt,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SKIP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       ext_pend_q, ext_pend_d;
    logic       brk_pend_q, brk_pend_d;
    logic [2:0] skip_cnt_q, skip_cnt_d;
    logic       in_pause_q, in_pause_d;
    logic       ev_break_q, ev_break_d;
    logic [7:0] ev_code_q, ev_code_d;
    logic       ev_ext_q, ev_ext_d;
    logic       key_valid_q, key_valid_d;
    logic [7:0] key_code_q, key_code_d;
    logic       key_ext_q, key_ext_d;
    logic [7:0] press_cnt_q, press_cnt_d;
    logic       err_q, err_d;
    logic       held_match;

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        skip_cnt_d  = skip_cnt_q;
        in_pause_d  = in_pause_q;
        ev_break_d  = ev_break_q;
        ev_code_d   = ev_code_q;
        ev_ext_d    = ev_ext_q;
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        press_cnt_d = press_cnt_q;
        err_d       = err_q;
        nextdata_n  = 1'b1;
        event_stb   = 1'b0;
        held_match  = key_valid_q && (key_ext_q == ext_pend_q) && (key_code_q == byte_q);

        case (state_q)
            IDLE, SKIP: begin
                if (ready) begin
                    nextdata_n = 1'b0;
                    byte_d     = data;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                state_d = IDLE;
                if (in_pause_q) begin
                    // Pause bytes are discarded; the last one releases a synthetic E1 make.
                    skip_cnt_d = skip_cnt_q - 3'd1;
                    if (skip_cnt_q == 3'd1) begin
                        in_pause_d  = 1'b0;
                        event_stb   = 1'b1;
                        ev_break_d  = 1'b0;
                        ev_code_d   = 8'hE1;
                        ev_ext_d    = 1'b0;
                        press_cnt_d = press_cnt_q + 8'd1;
                    end else begin
                        state_d = SKIP;
                    end
                end else begin
                    case (byte_q)
                        8'hE0: ext_pend_d = 1'b1;
                        8'hF0: brk_pend_d = 1'b1;
                        8'hE1: begin
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
                            if (PAUSE_LEN == 0) begin
                                event_stb   = 1'b1;
                                ev_break_d  = 1'b0;
                                ev_code_d   = 8'hE1;
                                ev_ext_d    = 1'b0;
                                press_cnt_d = press_cnt_q + 8'd1;
                            end else begin
                                skip_cnt_d = 3'(PAUSE_LEN);
                                in_pause_d = 1'b1;
                                state_d    = SKIP;
                            end
                        end
                        8'hAA, 8'hFA, 8'hEE, 8'hFE: begin
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
                        end
                        8'h00, 8'hFF: begin
                            err_d      = 1'b1;
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
                        end
                        default: begin
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
                            if (brk_pend_q) begin
                                event_stb  = 1'b1;
                                ev_break_d = 1'b1;
                                ev_code_d  = byte_q;
                                ev_ext_d   = ext_pend_q;
                                if (held_match) begin
                                    key_valid_d = 1'b0;
                                end
                            end else if (!held_match) begin
                                event_stb   = 1'b1;
                                ev_break_d  = 1'b0;
                                ev_code_d   = byte_q;
                                ev_ext_d    = ext_pend_q;
                                key_valid_d = 1'b1;
                                key_code_d  = byte_q;
                                key_ext_d   = ext_pend_q;
                                press_cnt_d = press_cnt_q + 8'd1;
                            end
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset suppresses any pop or event strobe in the same cycle.
        if (rst) begin
            nextdata_n = 1'b1;
            event_stb  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_q      <= 8'h00;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            skip_cnt_q  <= 3'd0;
            in_pause_q  <= 1'b0;
            ev_break_q  <= 1'b0;
            ev_code_q   <= 8'h00;
            ev_ext_q    <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            press_cnt_q <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            skip_cnt_q  <= skip_cnt_d;
            in_pause_q  <= in_pause_d;
            ev_break_q  <= ev_break_d;
            ev_code_q   <= ev_code_d;
            ev_ext_q    <= ev_ext_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            press_cnt_q <= press_cnt_d;
            err_q       <= err_d;
        end
    end

    assign event_break = ev_break_q;
    assign event_code  = ev_code_q;
    assign event_ext   = ev_ext_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign press_cnt   = press_cnt_q;
    assign err         = err_q;

endmodule
`default_nettype wire
